cat_throw_anim_ctrl: RTL and testbench

//  Sequences the cat player's throw animation by driving the 2-bit frame-select input of the cat sprite ROM.
//  - Frame select: 00 idle, 01 throw1, 10 throw2.
//  - On a throw request during the player's turn, steps through wind-up, release and recovery poses, timed in video frames.
//  - Emits a one-cycle release pulse for projectile spawn and a done pulse when the throw ends.
//  - Sits between game logic and image_rom_cat, in the player draw path.

---
 rtl/players_pkg.sv | 35 +++
 rtl/anim_hold_counter.sv | 46 ++++
 rtl/cat_throw_anim_ctrl.sv | 158 +++++++++++++++
 tb/tb_cat_throw_anim_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/players_pkg.sv
// Shared player-side types: throw animation states and sprite frame codes.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
//
// Contents:
//   anim_state_t  - throw animation FSM states
//   FRAME_*       - frame-select codes, also decoded by image_rom_cat
//   frame_of()    - state to frame-select decode
package players_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WIND    = 2'd1,
    RELEASE = 2'd2,
    RECOVER = 2'd3
  } anim_state_t;

  localparam logic [1:0] FRAME_IDLE   = 2'b00;
  localparam logic [1:0] FRAME_THROW1 = 2'b01;
  localparam logic [1:0] FRAME_THROW2 = 2'b10;

  // Wind-up and recovery share the throw1 pose; only release shows throw2.
  function automatic logic [1:0] frame_of(anim_state_t st);
    logic [1:0] f;
    f = FRAME_IDLE;
    case (st)
      WIND:    f = FRAME_THROW1;
      RELEASE: f = FRAME_THROW2;
      RECOVER: f = FRAME_THROW1;
      default: f = FRAME_IDLE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/anim_hold_counter.sv
// Hold timer for one animation pose, counting frame ticks since the pose began.
// Latency: expire is combinational on the tick that completes the hold.
// Backpressure: none; clear has priority over tick.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart the hold (asserted on every state entry)
//   tick      - count one frame
//   limit     - number of ticks the hold lasts (>= 1)
//   expire    - high when this tick is the limit-th one
module anim_hold_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Exit on the tick that would take the count to limit, so the count
  // itself never reaches limit and cannot wrap.
  assign expire = tick && (cnt_q == (limit - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cat_throw_anim_ctrl.sv
// Cat player throw animation sequencer driving the sprite ROM frame select.
// Latency: frame_sel/busy follow a start request by one cycle; pulses are registered.
// Backpressure: none; requests while busy are dropped, or queued one deep with CAT_ANIM_QUEUE_EN.
//
// Optional feature macro: CAT_ANIM_QUEUE_EN (one-deep pending throw request).
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   frame_tick     - one pulse per video frame
//   turn_active    - cat player may start a throw
//   throw_req      - one-cycle throw request
//   abort          - cancel animation immediately, no pulses
//   frame_sel      - sprite ROM frame select (00 idle, 01 throw1, 10 throw2)
//   busy           - animation in progress
//   release_pulse  - one cycle after WIND->RELEASE, spawns the projectile
//   done_pulse     - one cycle after RECOVER exit
module cat_throw_anim_ctrl
  import players_pkg::*;
#(
  parameter int WIND_FRAMES    = 8,
  parameter int RELEASE_FRAMES = 6,
  parameter int RECOVER_FRAMES = 4,
  parameter int CNT_W          = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       turn_active,
  input  logic       throw_req,
  input  logic       abort,
  output logic [1:0] frame_sel,
  output logic       busy,
  output logic       release_pulse,
  output logic       done_pulse
);

  localparam logic [CNT_W-1:0] WIND_LIM    = CNT_W'(WIND_FRAMES);
  localparam logic [CNT_W-1:0] RELEASE_LIM = CNT_W'(RELEASE_FRAMES);
  localparam logic [CNT_W-1:0] RECOVER_LIM = CNT_W'(RECOVER_FRAMES);

  anim_state_t      state_q, state_d;
  logic             release_q, release_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] hold_limit;
  logic             hold_clear;
  logic             hold_tick;
  logic             hold_expire;

`ifdef CAT_ANIM_QUEUE_EN
  logic             pending_q, pending_d;
`endif

  always_comb begin
    hold_limit = WIND_LIM;
    case (state_q)
      WIND:    hold_limit = WIND_LIM;
      RELEASE: hold_limit = RELEASE_LIM;
      RECOVER: hold_limit = RECOVER_LIM;
      default: hold_limit = WIND_LIM;
    endcase
  end

  // Any state change (including RECOVER->WIND chaining) restarts the hold.
  assign hold_clear = abort || (state_d != state_q);
  assign hold_tick  = frame_tick && (state_q != IDLE);

  anim_hold_counter #(
    .CNT_W (CNT_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clear  (hold_clear),
    .tick   (hold_tick),
    .limit  (hold_limit),
    .expire (hold_expire)
  );

  always_comb begin
    state_d   = state_q;
    release_d = 1'b0;
    done_d    = 1'b0;
`ifdef CAT_ANIM_QUEUE_EN
    pending_d = pending_q;
`endif
    if (abort) begin
      state_d = IDLE;
`ifdef CAT_ANIM_QUEUE_EN
      pending_d = 1'b0;
`endif
    end else begin
`ifdef CAT_ANIM_QUEUE_EN
      // A request that lands on the RECOVER exit cycle is consumed by the
      // exit below, which clears pending unconditionally.
      if ((state_q != IDLE) && throw_req) begin
        pending_d = 1'b1;
      end
`endif
      case (state_q)
        IDLE: begin
          if (throw_req && turn_active) begin
            state_d = WIND;
          end
        end
        WIND: begin
          if (hold_expire) begin
            state_d   = RELEASE;
            release_d = 1'b1;
          end
        end
        RELEASE: begin
          if (hold_expire) begin
            state_d = RECOVER;
          end
        end
        RECOVER: begin
          if (hold_expire) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef CAT_ANIM_QUEUE_EN
            if (pending_q && turn_active) begin
              state_d = WIND;
            end
            pending_d = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      release_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      release_q <= release_d;
      done_q    <= done_d;
    end
  end

`ifdef CAT_ANIM_QUEUE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end
`endif

  assign frame_sel     = frame_of(state_q);
  assign busy          = (state_q != IDLE);
  assign release_pulse = release_q;
  assign done_pulse    = done_q;

endmodule

// File: tb/tb_cat_throw_anim_ctrl.sv
// Directed bench for cat_throw_anim_ctrl (WIND=2, RELEASE=1, RECOVER=1 ticks,
// frame_tick every 4 clk). Outputs sampled on the falling edge, inputs driven
// right after sampling so each tick is charged to the state it was seen in.
module tb_cat_throw_anim_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       turn_active = 1'b0;
  logic       throw_req = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] frame_sel;
  logic       busy;
  logic       release_pulse;
  logic       done_pulse;

  cat_throw_anim_ctrl #(
    .WIND_FRAMES    (2),
    .RELEASE_FRAMES (1),
    .RECOVER_FRAMES (1),
    .CNT_W          (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .turn_active   (turn_active),
    .throw_req     (throw_req),
    .abort         (abort),
    .frame_sel     (frame_sel),
    .busy          (busy),
    .release_pulse (release_pulse),
    .done_pulse    (done_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0] s_sel;
  logic       s_busy, s_rel, s_done;

  // Run log: consecutive samples with equal frame_sel form one run.
  bit         rec = 1'b0;
  logic [1:0] run_val[$];
  int         run_tk[$];
  int         rel_cnt, done_cnt, rel_pos, done_pos;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    bit new_run;
    @(negedge clk);
    s_sel  = frame_sel;
    s_busy = busy;
    s_rel  = release_pulse;
    s_done = done_pulse;
    frame_tick = ((cyc % 4) == 3);
    cyc++;
    if (rec) begin
      new_run = (run_val.size() == 0) || (run_val[run_val.size()-1] != s_sel);
      if (new_run) begin
        run_val.push_back(s_sel);
        run_tk.push_back(0);
      end
      if (frame_tick) run_tk[run_tk.size()-1] = run_tk[run_tk.size()-1] + 1;
      if (s_rel) begin
        rel_cnt++;
        if (new_run && s_sel == 2'b10) rel_pos++;
      end
      if (s_done) begin
        done_cnt++;
        if (new_run && s_sel == 2'b00) done_pos++;
      end
    end
  endtask

  task automatic start_rec();
    run_val.delete();
    run_tk.delete();
    rel_cnt = 0; done_cnt = 0; rel_pos = 0; done_pos = 0;
    rec = 1'b1;
  endtask

  function automatic int pack_vals();
    int v = 0;
    foreach (run_val[i]) v = v * 4 + int'(run_val[i]);
    return v;
  endfunction

  // Ticks of every run except the trailing idle one.
  function automatic int pack_ticks();
    int t = 0;
    for (int i = 0; i < run_tk.size() - 1; i++) t = t * 16 + run_tk[i];
    return t;
  endfunction

  task automatic wait_sel(input logic [1:0] v, input string tag);
    int n = 0;
    while (s_sel != v && n < 200) begin
      step();
      n++;
    end
    check(tag, int'(s_sel == v), 1);
  endtask

  task automatic watch_idle(input int n, input string tag);
    int bad = 0;
    repeat (n) begin
      step();
      if (s_sel != 2'b00 || s_busy || s_rel || s_done) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic throw_and_check(input string tag, input bit second_req,
                                 input int exp_runs, input int exp_vals,
                                 input int exp_ticks, input int exp_rel,
                                 input int exp_done);
    step();
    turn_active = 1'b1;
    throw_req = 1'b1;
    start_rec();
    step();
    throw_req = 1'b0;
    check({tag, "_lat_sel"}, int'(s_sel), 1);
    check({tag, "_lat_busy"}, int'(s_busy), 1);
    if (second_req) begin
      step();
      throw_req = 1'b1;
      step();
      throw_req = 1'b0;
    end
    wait_sel(2'b00, {tag, "_end"});
    repeat (6) step();
    rec = 1'b0;
    check({tag, "_nruns"}, run_val.size(), exp_runs);
    check({tag, "_seq"}, pack_vals(), exp_vals);
    check({tag, "_ticks"}, pack_ticks(), exp_ticks);
    check({tag, "_rel_cnt"}, rel_cnt, exp_rel);
    check({tag, "_rel_pos"}, rel_pos, exp_rel);
    check({tag, "_done_cnt"}, done_cnt, exp_done);
    check({tag, "_done_pos"}, done_pos, 1);
  endtask

  // Single throw: runs 01,10,01,00 with 2,1,1 ticks.
  localparam int SINGLE_VALS  = 1 * 64 + 2 * 16 + 1 * 4 + 0;
  localparam int SINGLE_TICKS = 2 * 256 + 1 * 16 + 1;

  initial begin
    // 1. reset then quiet idle
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_sel", int'(s_sel), 0);
    check("rst_busy", int'(s_busy), 0);
    check("rst_rel", int'(s_rel), 0);
    check("rst_done", int'(s_done), 0);
    watch_idle(20, "idle_quiet");

    // 2. basic throw
    throw_and_check("throw", 1'b0, 4, SINGLE_VALS, SINGLE_TICKS, 1, 1);

    // 3. request outside the player's turn
    turn_active = 1'b0;
    throw_req = 1'b1;
    step();
    throw_req = 1'b0;
    step();
    check("noturn_sel", int'(s_sel), 0);
    check("noturn_busy", int'(s_busy), 0);
    watch_idle(20, "noturn_idle");

    // 4a. abort during RELEASE
    turn_active = 1'b1;
    throw_req = 1'b1;
    step();
    throw_req = 1'b0;
    wait_sel(2'b10, "abort_reach_rel");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_sel", int'(s_sel), 0);
    check("abort_busy", int'(s_busy), 0);
    check("abort_done", int'(s_done), 0);
    watch_idle(30, "abort_idle");

    // 4b. abort wins over a simultaneous start
    throw_req = 1'b1;
    abort = 1'b1;
    step();
    throw_req = 1'b0;
    abort = 1'b0;
    step();
    check("abort_req_sel", int'(s_sel), 0);
    check("abort_req_busy", int'(s_busy), 0);
    watch_idle(20, "abort_req_idle");

    // 5. second request during WIND
`ifdef CAT_ANIM_QUEUE_EN
    // runs 01,10,01(RECOVER+WIND merged),10,01,00; ticks 2,1,3,1,1
    throw_and_check("queue", 1'b1, 6,
                    1 * 1024 + 2 * 256 + 1 * 64 + 2 * 16 + 1 * 4 + 0,
                    2 * 65536 + 1 * 4096 + 3 * 256 + 1 * 16 + 1, 2, 2);
`else
    throw_and_check("queue", 1'b1, 4, SINGLE_VALS, SINGLE_TICKS, 1, 1);
`endif

    // 6. reset in WIND with a second request already seen
    step();
    throw_req = 1'b1;
    step();
    check("rstwind_in_wind", int'(s_sel), 1);
    step();
    throw_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstwind_sel", int'(s_sel), 0);
    check("rstwind_busy", int'(s_busy), 0);
    check("rstwind_rel", int'(s_rel), 0);
    watch_idle(60, "rstwind_idle");
    // No stale pending request: the next throw must be a single one.
    throw_and_check("after_rst", 1'b0, 4, SINGLE_VALS, SINGLE_TICKS, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
